// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared constants and helpers for the sync_adder datapath and its result sink.
//   ADDER_WIDTH_DEFAULT : default adder operand width
//   SAT_MAX_W           : widest accumulator sat_add can handle
//   sum_width(w)        : width of an adder sum for w-bit operands (carry kept)
//   sat_add(a, v, w)    : saturating a + v limited to w bits, returns {sat, result}
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int unsigned ADDER_WIDTH_DEFAULT = 8;
    localparam int unsigned SAT_MAX_W           = 64;

    function automatic int unsigned sum_width(input int unsigned w);
        return w + 1;
    endfunction

    // Operands arrive zero-extended to SAT_MAX_W bits; the extra result bit
    // catches the carry so that even a full-width accumulator saturates
    // correctly. Result is {sat_flag, value}.
    function automatic logic [SAT_MAX_W:0] sat_add(input logic [SAT_MAX_W-1:0] acc,
                                                   input logic [SAT_MAX_W-1:0] val,
                                                   input int unsigned          accw);
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] limit;
        sum   = {1'b0, acc} + {1'b0, val};
        limit = ({{SAT_MAX_W{1'b0}}, 1'b1} << accw) - {{SAT_MAX_W{1'b0}}, 1'b1};
        if (sum > limit) begin
            return {1'b1, limit[SAT_MAX_W-1:0]};
        end
        return {1'b0, sum[SAT_MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/adder_result_sink_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// First-word-fall-through FIFO with an explicit occupancy counter.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   clear_i        : synchronous flush, wins over push and pop
//   push_i, data_i : write request and data (no backpressure on the writer)
//   ready_i        : consumer takes the head this cycle
//   valid_o/data_o : head of the queue, driven from registered state only
//   count_o        : occupancy 0..Depth; full_o / empty_o decoded from it
//   accept_o       : the write request is stored this cycle
//   drop_o         : the write request is lost (full and no pop)
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int unsigned Width = 9,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic [CntW-1:0]  count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             accept_o,
    output logic             drop_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full, empty, pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(Depth));
    assign valid_o = !empty;
    // Storage is zeroed on reset/clear, so the head reads 0 in the idle state.
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full;
    assign empty_o = empty;

    always_comb begin
        pop      = valid_o & ready_i & !clear_i;
        // A pop frees the head slot on the same edge, so a full FIFO still accepts.
        accept_o = push_i & (!full | pop) & !clear_i;
        drop_o   = push_i & full & !pop & !clear_i;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (clear_i) begin
            mem_d    = '{default: '0};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (accept_o) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({accept_o, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/adder_result_sink.sv
// -----------------------------------------------------------------------------
// adder_result_sink
// Receiving end of sync_adder: buffers every valid sum in a small FWFT FIFO,
// hands results downstream on ready/valid, and keeps a saturating running
// total plus sticky overflow (sum dropped) and acc_sat (total clipped) flags.
//   clk, rst          : clock, asynchronous active-high reset
//   clear             : synchronous flush of FIFO, acc and both sticky flags
//   in_valid, in_sum  : adder result stream (no backpressure)
//   out_valid/out_ready/out_data : downstream handshake, head of FIFO
//   count, full, empty: FIFO occupancy status
//   overflow          : sticky, a valid sum arrived while full with no pop
//   acc, acc_sat      : saturating sum of accepted results, sticky saturation
// -----------------------------------------------------------------------------
module adder_result_sink
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH     = ADDER_WIDTH_DEFAULT,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ACC_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic [sum_width(WIDTH)-1:0]    in_sum,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [sum_width(WIDTH)-1:0]    out_data,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           full,
    output logic                           empty,
    output logic                           overflow,
    output logic [ACC_WIDTH-1:0]           acc,
    output logic                           acc_sat
);

    localparam int unsigned SumW = sum_width(WIDTH);

    logic                 accept, drop;
    logic                 overflow_q, overflow_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 acc_sat_q, acc_sat_d;
    logic [SAT_MAX_W:0]   sat_res;
    logic                 unused_sat_res;

    sync_fifo_fwft #(
        .Width (SumW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (clear),
        .push_i   (in_valid),
        .data_i   (in_sum),
        .ready_i  (out_ready),
        .valid_o  (out_valid),
        .data_o   (out_data),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty),
        .accept_o (accept),
        .drop_o   (drop)
    );

    assign sat_res        = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(in_sum), ACC_WIDTH);
    // Upper bits of sat_res beyond ACC_WIDTH are always zero by construction.
    assign unused_sat_res = ^sat_res;

    always_comb begin
        overflow_d = overflow_q;
        acc_d      = acc_q;
        acc_sat_d  = acc_sat_q;
        if (clear) begin
            overflow_d = 1'b0;
            acc_d      = '0;
            acc_sat_d  = 1'b0;
        end else begin
            if (drop) begin
                overflow_d = 1'b1;
            end
            // Only stored sums count; dropped ones leave the total untouched.
            if (accept) begin
                acc_d     = sat_res[ACC_WIDTH-1:0];
                acc_sat_d = acc_sat_q | sat_res[SAT_MAX_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            acc_q      <= '0;
            acc_sat_q  <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            acc_q      <= acc_d;
            acc_sat_q  <= acc_sat_d;
        end
    end

    assign overflow = overflow_q;
    assign acc      = acc_q;
    assign acc_sat  = acc_sat_q;

endmodule

// File: tb/tb_adder_result_sink.sv
// -----------------------------------------------------------------------------
// tb_adder_result_sink
// Directed bench for adder_result_sink (WIDTH=8, DEPTH=4, ACC_WIDTH=10 so the
// saturation boundary is reachable with 9-bit sums).
// -----------------------------------------------------------------------------
module tb_adder_result_sink;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [8:0] in_sum;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [9:0] acc;
    logic       acc_sat;

    int checks = 0;
    int errors = 0;

    adder_result_sink #(
        .WIDTH     (8),
        .DEPTH     (4),
        .ACC_WIDTH (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .acc       (acc),
        .acc_sat   (acc_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic push(input int v);
        in_valid = 1'b1;
        in_sum   = 9'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out_valid, out_data, count, full, empty, overflow, acc, acc_sat} !==
            {1'b0, 9'd0, 3'd0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in got v=%b d=%0d c=%0d f=%b e=%b o=%b a=%0d s=%b want 0 0 0 0 1 0 0 0",
                     out_valid, out_data, count, full, empty, overflow, acc, acc_sat);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if ({out_valid, count, empty, acc} !== {1'b0, 3'd0, 1'b1, 10'd0}) begin
            errors++;
            $display("FAIL reset_out got v=%b c=%0d e=%b a=%0d want 0 0 1 0",
                     out_valid, count, empty, acc);
        end
    endtask

    task automatic test_fall_through();
        out_ready = 1'b0;
        push(15 + 55);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL ft_valid got %b want 1", out_valid);
        end
        checks++;
        if (out_data !== 9'd70) begin
            errors++; $display("FAIL ft_data got %0d want 70", out_data);
        end
        checks++;
        if (count !== 3'd1 || acc !== 10'd70) begin
            errors++; $display("FAIL ft_count_acc got c=%0d a=%0d want 1 70", count, acc);
        end
        // Head must hold while not accepted.
        tick();
        checks++;
        if (out_data !== 9'd70 || count !== 3'd1) begin
            errors++; $display("FAIL ft_hold got d=%0d c=%0d want 70 1", out_data, count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL ft_pop got e=%b v=%b want 1 0", empty, out_valid);
        end
    endtask

    task automatic test_fill_overflow();
        int exp_q[4] = '{300, 510, 0, 100};
        do_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(exp_q[i]);
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || acc !== 10'd910) begin
            errors++;
            $display("FAIL fill got f=%b c=%0d a=%0d want 1 4 910", full, count, acc);
        end
        push(7);
        checks++;
        if (overflow !== 1'b1 || acc !== 10'd910 || count !== 3'd4) begin
            errors++;
            $display("FAIL drop got o=%b a=%0d c=%0d want 1 910 4", overflow, acc, count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 9'(exp_q[i])) begin
                errors++;
                $display("FAIL drain%0d got v=%b d=%0d want 1 %0d", i, out_valid, out_data,
                         exp_q[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL drain_end got e=%b o=%b want 1 1", empty, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int heads[3] = '{20, 30, 40};
        int tail[4]  = '{40, 1, 2, 3};
        do_clear();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(10 * i);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(i + 1);
            checks++;
            if (count !== 3'd4 || overflow !== 1'b0 || out_data !== 9'(heads[i])) begin
                errors++;
                $display("FAIL b2b%0d got c=%0d o=%b d=%0d want 4 0 %0d", i, count, overflow,
                         out_data, heads[i]);
            end
        end
        checks++;
        if (acc !== 10'd106) begin
            errors++; $display("FAIL b2b_acc got %0d want 106", acc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_data !== 9'(tail[i])) begin
                errors++; $display("FAIL b2b_drain%0d got %0d want %0d", i, out_data, tail[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL b2b_empty got %b want 1", empty);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        out_ready = 1'b1;
        push(510);
        push(510);
        push(3);
        checks++;
        if (acc !== 10'd1023 || acc_sat !== 1'b0) begin
            errors++; $display("FAIL sat_edge got a=%0d s=%b want 1023 0", acc, acc_sat);
        end
        push(1);
        checks++;
        if (acc !== 10'd1023 || acc_sat !== 1'b1) begin
            errors++; $display("FAIL sat_over got a=%0d s=%b want 1023 1", acc, acc_sat);
        end
        do_clear();
        push(510);
        push(510);
        push(10);
        checks++;
        if (acc !== 10'd1023 || acc_sat !== 1'b1) begin
            errors++; $display("FAIL sat_plan got a=%0d s=%b want 1023 1", acc, acc_sat);
        end
        push(0);
        checks++;
        if (acc !== 10'd1023 || acc_sat !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold got a=%0d s=%b o=%b want 1023 1 0", acc, acc_sat, overflow);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_clear();
        do_clear();
        out_ready = 1'b0;
        for (int i = 5; i <= 9; i++) push(i);
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            errors++; $display("FAIL clr_pre got o=%b c=%0d want 1 4", overflow, count);
        end
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_sum    = 9'd99;
        out_ready = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data, count, full, empty, overflow, acc, acc_sat} !==
            {1'b0, 9'd0, 3'd0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0}) begin
            errors++;
            $display("FAIL clr_state got v=%b d=%0d c=%0d f=%b e=%b o=%b a=%0d s=%b want 0 0 0 0 1 0 0 0",
                     out_valid, out_data, count, full, empty, overflow, acc, acc_sat);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || acc !== 10'd0) begin
            errors++; $display("FAIL clr_absent got e=%b a=%0d want 1 0", empty, acc);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        out_ready = 1'b0;
        push(11);
        push(22);
        checks++;
        if (count !== 3'd2 || acc !== 10'd33) begin
            errors++; $display("FAIL ar_pre got c=%0d a=%0d want 2 33", count, acc);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_data, count, full, empty, acc} !==
            {1'b0, 9'd0, 3'd0, 1'b0, 1'b1, 10'd0}) begin
            errors++;
            $display("FAIL ar_now got v=%b d=%0d c=%0d f=%b e=%b a=%0d want 0 0 0 0 1 0",
                     out_valid, out_data, count, full, empty, acc);
        end
        #1;
        rst = 1'b0;
        push(42);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 9'd42 || count !== 3'd1 || acc !== 10'd42) begin
            errors++;
            $display("FAIL ar_after got v=%b d=%0d c=%0d a=%0d want 1 42 1 42",
                     out_valid, out_data, count, acc);
        end
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        out_ready = 1'b0;
        test_reset();
        test_fall_through();
        test_fill_overflow();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_result_sink.md
Name: adder_result_sink

Overview:
Receiving end of the sync_adder output interface (sum/valid). Captures every valid sum into a small first-word-fall-through FIFO. Presents the results downstream on a ready/valid handshake. Keeps a saturating running total and a sticky overflow flag. Sits directly after sync_adder in the datapath and decouples the adder (which has no backpressure) from slower consumers.

Parameters:
WIDTH, 8, adder operand width; sum width is WIDTH+1
DEPTH, 4, FIFO entries; power of two, ≥2
ACC_WIDTH, 16, running-total width; must be ≥ WIDTH+1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
clear  input  1  synchronous flush: empties FIFO, zeroes acc, clears overflow
in_valid  input  1  adder valid; one result per cycle while high
in_sum  input  WIDTH+1  adder sum
out_valid  output  1  FIFO head holds data
out_ready  input  1  consumer accepts head this cycle
out_data  output  WIDTH+1  FIFO head value
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky; a valid sum was dropped
acc  output  ACC_WIDTH  saturating sum of all accepted in_sum since reset/clear
acc_sat  output  1  sticky; acc has saturated

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: out_valid=0, out_data=0, count=0, full=0, empty=1, overflow=0, acc=0, acc_sat=0. Read/write pointers are 0.
- Reset asserted mid-operation discards all stored data immediately. No output glitches beyond the async clear.
- pop = out_valid & out_ready. push_req = in_valid.
- push accepted = push_req & (!full | pop). A full FIFO with a simultaneous pop accepts the push, and count stays DEPTH.
- push_req & full & !pop: the sum is dropped, overflow is set (sticky), and acc does not change.
- pop on empty cannot occur, because out_valid=0 when empty.
- Push+pop on the same edge with count≥1: count is unchanged, pointers both advance, and ordering is preserved.
- Push on empty at edge N: out_valid=1 and out_data=in_sum right after edge N (fall-through, latency 1 edge). The same edge cannot also pop.
- out_data changes only after an edge with a pop or a push-into-empty. It is stable while out_valid & !out_ready.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- acc update on each accepted push: acc_next = acc + zero-extended in_sum.
  - If acc_next > 2^ACC_WIDTH−1, acc holds at all-ones and acc_sat is set.
  - Once saturated, acc stays all-ones until clear or rst.
- clear has priority over push and pop in the same cycle. After that edge, the state equals the reset state, and the in_sum of that cycle is discarded (not counted as overflow).
- No combinational path from in_valid/in_sum to out_*. out_valid depends only on registered state. out_ready affects only the next state.

Decomposition:
- Package adder_pkg holds:
  - constant ADDER_WIDTH_DEFAULT = 8
  - function sum_width(w) = w+1
  - function sat_add(acc, val, accw), which returns {sat_flag, result}
- Natural sub-module: sync_fifo_fwft, parameterised by data width and DEPTH.
  - Handles the pointers, count, full/empty, and the push-while-full-with-pop rule.
  - adder_result_sink adds the overflow, acc and clear logic around it.

Test Plan:
1. Reset, then push 70 (15+55) with out_ready=0 → after 1 edge: out_valid=1, out_data=70, count=1, acc=70. Raise out_ready → after 1 edge: empty=1.
2. out_ready=0, push 300, 510, 0, 100 on consecutive cycles → full=1, count=4, acc=910. A 5th push of 7 → overflow=1, acc stays 910. Drain reads exactly 300, 510, 0, 100.
3. Full FIFO, out_ready=1, in_valid=1 with 1, 2, 3 over 3 cycles → count stays 4, no overflow, output order continues from the old head.
4. ACC_WIDTH=10: push 510, 510, 10 → acc=1023 (saturated), acc_sat=1. A further push of 0 leaves acc=1023.
5. Push 3 entries, then assert clear together with in_valid and out_ready → next cycle state equals reset state, overflow=0, and the in_sum of that cycle is absent.
6. Assert rst asynchronously between clock edges while count=2 → outputs go to reset values immediately. After release, a push of 42 reads back 42.
